// File: rtl/rom_load_ctrl.sv
// ROM download controller: captures HPS ioctl byte strobes, forwards them to a
// ROM store with a write/ack handshake, and sequences the arcade core reset.
module rom_load_ctrl #(
  parameter logic [7:0]  ROM_INDEX   = 8'h00,
  parameter int unsigned HOLD_CYCLES = 1024
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [16:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic [16:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_we,
  output logic [2:0]  mem_cs,
  input  logic        mem_ack,
  output logic        core_reset,
  output logic        load_done,
  output logic [17:0] byte_count,
  output logic        overrun
);

  localparam int unsigned AW = 17;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 18;
  localparam int unsigned HW = 16;
  localparam logic [CW-1:0] BYTE_MAX  = CW'(18'h20000);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_HOLD  = 3'd3,
    S_RUN   = 3'd4
  } state_t;

  state_t        state_q;
  logic          ioctl_wait_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_din_q;
  logic          mem_we_q;
  logic [2:0]    mem_cs_q;
  logic          core_reset_q;
  logic          load_done_q;
  logic [CW-1:0] byte_count_q;
  logic          overrun_q;
  logic [HW-1:0] hold_cnt_q;

  logic          idx_match;
  logic          dl_match;
  logic          wr_accept;
  logic          enter_load;
  logic [2:0]    cs_d;
  logic [CW-1:0] byte_count_d;

  // Request qualification and the decision to (re)start a download.
  always_comb begin
    idx_match  = (ioctl_index == ROM_INDEX);
    dl_match   = ioctl_download && idx_match;
    wr_accept  = ioctl_wr && idx_match;
    enter_load = dl_match &&
                 ((state_q == S_IDLE) || (state_q == S_HOLD) || (state_q == S_RUN));
  end

  // Region select from the top address bits: CPU, sound, gfx.
  always_comb begin
    cs_d = 3'b001;
    case (ioctl_addr[16:15])
      2'b10:   cs_d = 3'b010;
      2'b11:   cs_d = 3'b100;
      default: cs_d = 3'b001;
    endcase
  end

  // Saturating byte counter increment.
  always_comb begin
    byte_count_d = byte_count_q;
    if (byte_count_q < BYTE_MAX) begin
      byte_count_d = byte_count_q + CW'(1);
    end
  end

  // Download sequencer with registered outputs.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      ioctl_wait_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      mem_we_q     <= 1'b0;
      mem_cs_q     <= 3'b000;
      core_reset_q <= 1'b1;
      load_done_q  <= 1'b0;
      byte_count_q <= '0;
      overrun_q    <= 1'b0;
      hold_cnt_q   <= '0;
    end else if (enter_load) begin
      state_q      <= S_LOAD;
      byte_count_q <= '0;
      overrun_q    <= 1'b0;
      load_done_q  <= 1'b0;
      core_reset_q <= 1'b1;
      hold_cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          core_reset_q <= 1'b1;
          load_done_q  <= 1'b0;
        end
        S_LOAD: begin
          // A strobe wins over a simultaneous download fall; HOLD follows the write.
          if (wr_accept) begin
            mem_we_q     <= 1'b1;
            ioctl_wait_q <= 1'b1;
            mem_addr_q   <= ioctl_addr;
            mem_din_q    <= ioctl_dout;
            mem_cs_q     <= cs_d;
            state_q      <= S_WRITE;
          end else if (!ioctl_download) begin
            hold_cnt_q <= '0;
            state_q    <= S_HOLD;
          end
        end
        S_WRITE: begin
          if (wr_accept) begin
            overrun_q <= 1'b1;
          end
          if (mem_ack) begin
            mem_we_q     <= 1'b0;
            ioctl_wait_q <= 1'b0;
            mem_cs_q     <= 3'b000;
            byte_count_q <= byte_count_d;
            state_q      <= S_LOAD;
          end
        end
        S_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            core_reset_q <= 1'b0;
            load_done_q  <= 1'b1;
            state_q      <= S_RUN;
          end else begin
            hold_cnt_q <= hold_cnt_q + HW'(1);
          end
        end
        S_RUN: begin
          core_reset_q <= 1'b0;
          load_done_q  <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ioctl_wait = ioctl_wait_q;
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  assign mem_we     = mem_we_q;
  assign mem_cs     = mem_cs_q;
  assign core_reset = core_reset_q;
  assign load_done  = load_done_q;
  assign byte_count = byte_count_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Bench for rom_load_ctrl: randomized downloads, a queue of expected store
// writes, and a negedge monitor that pops and compares at each accepted write.
module tb_rom_load_ctrl;

  localparam logic [7:0] ROM_IDX = 8'h00;
  localparam int         HOLD    = 1024;

  logic        clk_sys;
  logic        reset_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [16:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic [16:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_we;
  logic [2:0]  mem_cs;
  logic        mem_ack;
  logic        core_reset;
  logic        load_done;
  logic [17:0] byte_count;
  logic        overrun;

  rom_load_ctrl #(.ROM_INDEX(ROM_IDX), .HOLD_CYCLES(HOLD)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_we(mem_we), .mem_cs(mem_cs), .mem_ack(mem_ack),
    .core_reset(core_reset), .load_done(load_done), .byte_count(byte_count),
    .overrun(overrun)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [16:0] a;
    logic [7:0]  d;
    logic [2:0]  cs;
    int          hi;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          exp_count = 0;
  logic        exp_ovr = 1'b0;
  logic        mon_en = 1'b0;
  int          we_rises = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Region from address ranges.
  function automatic logic [2:0] region(input logic [16:0] a);
    if (a < 17'h10000)      return 3'b001;
    else if (a < 17'h18000) return 3'b010;
    else                    return 3'b100;
  endfunction

  function automatic int sat_inc(input int c);
    return (c < 32'h20000) ? c + 1 : c;
  endfunction

  // Monitor: tracks each store write, checks stability, pops on the ack.
  logic [16:0] cap_a;
  logic [7:0]  cap_d;
  logic [2:0]  cap_cs;
  int          hi_cnt;
  logic        in_wr = 1'b0;
  logic        unstable;
  exp_t        e;
  always @(negedge clk_sys) begin
    if (mon_en) begin
      if (mem_we === 1'b1) begin
        if (!in_wr) begin
          in_wr    = 1'b1;
          cap_a    = mem_addr;
          cap_d    = mem_din;
          cap_cs   = mem_cs;
          hi_cnt   = 0;
          unstable = 1'b0;
          we_rises++;
        end
        hi_cnt++;
        if (mem_addr !== cap_a || mem_din !== cap_d || mem_cs !== cap_cs || ioctl_wait !== 1'b1)
          unstable = 1'b1;
        if (mem_ack === 1'b1) begin
          in_wr = 1'b0;
          chk("write_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("mem_addr", 32'(cap_a), 32'(e.a));
            chk("mem_din", 32'(cap_d), 32'(e.d));
            chk("mem_cs", 32'(cap_cs), 32'(e.cs));
            chk("we_cycles", 32'(hi_cnt), 32'(e.hi));
            chk("stable", 32'(unstable), 32'd0);
          end
        end
      end else begin
        in_wr = 1'b0;
        chk("cs_idle", 32'(mem_cs), 32'd0);
      end
    end
  end

  // One byte transfer; entry and exit at #1 after a rising edge.
  // dly: cycles before ack; extra_at: window cycle of a dropped strobe (0 none);
  // drop_at: cycle the download falls (0 = with the strobe, -1 never).
  task automatic do_write(input logic [16:0] a, input logic [7:0] d, input int dly,
                          input int extra_at, input int drop_at);
    exp_t x;
    ioctl_index = ROM_IDX;
    ioctl_wr    = 1'b1;
    ioctl_addr  = a;
    ioctl_dout  = d;
    if (drop_at == 0) ioctl_download = 1'b0;
    x.a = a; x.d = d; x.cs = region(a); x.hi = dly + 1;
    exp_q.push_back(x);
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
    for (int i = 1; i <= dly; i++) begin
      ioctl_wr = (i == extra_at);
      if (i == extra_at) begin
        ioctl_addr = 17'($urandom);
        ioctl_dout = 8'($urandom);
        exp_ovr    = 1'b1;
      end
      if (i == drop_at) ioctl_download = 1'b0;
      @(posedge clk_sys); #1;
    end
    ioctl_wr = 1'b0;
    mem_ack  = 1'b1;
    @(posedge clk_sys); #1;
    mem_ack   = 1'b0;
    exp_count = sat_inc(exp_count);
    chk("byte_count", 32'(byte_count), 32'(exp_count));
    chk("wait_released", 32'(ioctl_wait), 32'd0);
    chk("we_released", 32'(mem_we), 32'd0);
  endtask

  // Called in LOAD with the download already low; next edge enters HOLD.
  task automatic measure_hold();
    int n;
    @(posedge clk_sys); #1;
    chk("hold_load_done", 32'(load_done), 32'd0);
    n = 0;
    while (core_reset === 1'b1 && n < 3000) begin
      n++;
      @(posedge clk_sys); #1;
    end
    chk("hold_len", 32'(n), 32'(HOLD));
    chk("run_core_reset", 32'(core_reset), 32'd0);
    chk("run_load_done", 32'(load_done), 32'd1);
  endtask

  task automatic start_load(input string tag);
    ioctl_index    = ROM_IDX;
    ioctl_download = 1'b1;
    @(posedge clk_sys); #1;
    exp_count = 0;
    exp_ovr   = 1'b0;
    chk({tag, "_core_reset"}, 32'(core_reset), 32'd1);
    chk({tag, "_load_done"}, 32'(load_done), 32'd0);
    chk({tag, "_byte_count"}, 32'(byte_count), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int rises0;
    int dly;
    int extra;
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'h00; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; mem_ack = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_cs", 32'(mem_cs), 32'd0);
    chk("rst_wait", 32'(ioctl_wait), 32'd0);
    chk("rst_byte_count", 32'(byte_count), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_din", 32'(mem_din), 32'd0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    @(posedge clk_sys); #1;

    // Wrong index: strobes are ignored, nothing starts.
    rises0 = we_rises;
    ioctl_index = 8'h01; ioctl_download = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk_sys); #1;
      ioctl_wr = 1'b1; ioctl_addr = 17'($urandom); ioctl_dout = 8'($urandom);
      @(posedge clk_sys); #1;
      ioctl_wr = 1'b0;
    end
    repeat (3) @(posedge clk_sys);
    #1;
    chk("wrongidx_writes", 32'(we_rises - rises0), 32'd0);
    chk("wrongidx_count", 32'(byte_count), 32'd0);
    chk("wrongidx_core_reset", 32'(core_reset), 32'd1);
    chk("wrongidx_load_done", 32'(load_done), 32'd0);
    ioctl_download = 1'b0;
    @(posedge clk_sys); #1;

    // Basic three-region load followed by the reset hold.
    start_load("basic");
    do_write(17'h00000, 8'hA5, 2, 0, -1);
    do_write(17'h10000, 8'h5A, 2, 0, -1);
    do_write(17'h18000, 8'hFF, 2, 0, -1);
    chk("basic_count", 32'(byte_count), 32'd3);
    ioctl_download = 1'b0;
    measure_hold();

    // Stay in RUN then reload.
    repeat (100) @(posedge clk_sys);
    #1;
    chk("run_steady", 32'({core_reset, load_done}), 32'b01);
    start_load("reload");

    // Back-pressure with a dropped strobe inside the window.
    do_write(17'($urandom), 8'($urandom), 10, 4, -1);
    chk("bp_overrun", 32'(overrun), 32'd1);
    chk("bp_count", 32'(byte_count), 32'd1);

    // Random traffic with stray acks and foreign-index strobes in the gaps.
    for (int k = 0; k < 20; k++) begin
      dly   = int'($urandom_range(0, 5));
      extra = (dly >= 2 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, dly)) : 0;
      do_write(17'($urandom), 8'($urandom), dly, extra, -1);
      for (int g = int'($urandom_range(0, 3)); g > 0; g--) begin
        case ($urandom_range(0, 3))
          0: mem_ack = 1'b1;
          1: begin
            ioctl_index = 8'($urandom_range(1, 255));
            ioctl_wr    = 1'b1;
            ioctl_addr  = 17'($urandom);
          end
          default: ;
        endcase
        @(posedge clk_sys); #1;
        mem_ack = 1'b0; ioctl_wr = 1'b0; ioctl_index = ROM_IDX;
      end
    end
    chk("rand_count", 32'(byte_count), 32'(exp_count));
    chk("rand_overrun", 32'(overrun), 32'(exp_ovr));

    // Download falls while a write is pending; write completes before HOLD.
    do_write(17'($urandom), 8'($urandom), 4, 0, 1);
    chk("pending_core_reset", 32'(core_reset), 32'd1);
    measure_hold();

    // Strobe coincides with the download fall.
    start_load("coinc");
    do_write(17'($urandom), 8'($urandom), 2, 0, 0);
    chk("coinc_count", 32'(byte_count), 32'd1);
    measure_hold();

    // Zero-byte download still reaches RUN.
    start_load("empty");
    repeat (3) @(posedge clk_sys);
    #1;
    ioctl_download = 1'b0;
    measure_hold();

    // Restart during HOLD aborts the count.
    start_load("abort");
    ioctl_download = 1'b0;
    repeat (500) @(posedge clk_sys);
    #1;
    chk("abort_in_hold", 32'({core_reset, load_done}), 32'b10);
    start_load("abort_restart");
    ioctl_download = 1'b0;
    measure_hold();

    // Reset in the middle of a write; a late ack must be ignored.
    start_load("midrst");
    ioctl_wr = 1'b1; ioctl_addr = 17'($urandom); ioctl_dout = 8'($urandom);
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
    chk("midrst_we_up", 32'(mem_we), 32'd1);
    repeat (2) @(posedge clk_sys);
    #1;
    reset_n = 1'b0; ioctl_download = 1'b0;
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    chk("midrst_we", 32'(mem_we), 32'd0);
    chk("midrst_wait", 32'(ioctl_wait), 32'd0);
    chk("midrst_core_reset", 32'(core_reset), 32'd1);
    chk("midrst_count", 32'(byte_count), 32'd0);
    mem_ack = 1'b1;
    @(posedge clk_sys); #1;
    mem_ack = 1'b0;
    chk("late_ack_we", 32'(mem_we), 32'd0);
    chk("late_ack_count", 32'(byte_count), 32'd0);
    repeat (HOLD + 50) @(posedge clk_sys);
    #1;
    chk("midrst_idle", 32'({core_reset, load_done}), 32'b10);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
